// File: rtl/spi_pkg.sv
// Shared types and constants for the Mini_SPI master.
// Only mode 0 is built today; the mode constants mark where a future mode extension would hook in.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEAD,
    HIGH,
    LOW,
    TRAIL
  } spi_state_t;

  localparam logic SPI_CPOL = 1'b0;
  localparam logic SPI_CPHA = 1'b0;

endpackage

// File: rtl/spi_sclk_gen.sv
// Half-period divider: pulses o_tick on every CLK_DIV-th enabled cycle.
// The count restarts from zero whenever the block is disabled.
module spi_sclk_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic clear,
  input  logic i_en,
  output logic o_tick
);

  localparam int DW = (CLK_DIV < 2) ? 1 : $clog2(CLK_DIV + 1);

  logic [DW-1:0] r_divCnt;
  logic          w_last;

  assign w_last = (r_divCnt == DW'(CLK_DIV - 1));
  assign o_tick = i_en && w_last;

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      r_divCnt <= '0;
    end else if (!i_en || w_last) begin
      r_divCnt <= '0;
    end else begin
      r_divCnt <= r_divCnt + DW'(1);
    end
  end

endmodule

// File: rtl/spi_master_ctrl.sv
// Mode-0 SPI master sequencer: one full-duplex WIDTH-bit transfer per accepted start,
// with chip-select framing, SCLK generation, MOSI shift-out and MISO capture.
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int CLK_DIV   = 2,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             start,
  input  logic [WIDTH-1:0] txData,
  input  logic             miso,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rxData,
  output logic             sclk,
  output logic             mosi,
  output logic             csN
);

  localparam int   BW          = $clog2(WIDTH + 1);
  localparam logic CAP_ON_LEAD = (SPI_CPHA == 1'b0);

  spi_state_t       r_state;
  logic [WIDTH-1:0] r_tx;
  logic [WIDTH-1:0] r_rx;
  logic [WIDTH-1:0] r_rxData;
  logic [BW-1:0]    r_bitCnt;
  logic             r_trailHold;
  logic             r_busy;
  logic             r_done;
  logic             r_sclk;
  logic             r_mosi;
  logic             r_csN;
  logic             w_divEn;
  logic             w_tick;

  function automatic logic first_bit(input logic [WIDTH-1:0] v);
    return (MSB_FIRST != 0) ? v[WIDTH-1] : v[0];
  endfunction

  function automatic logic [WIDTH-1:0] shift_tx(input logic [WIDTH-1:0] v);
    return (MSB_FIRST != 0) ? (v << 1) : (v >> 1);
  endfunction

  function automatic logic [WIDTH-1:0] capture(input logic [WIDTH-1:0] v, input logic b);
    return (MSB_FIRST != 0) ? {v[WIDTH-2:0], b} : {b, v[WIDTH-1:1]};
  endfunction

  assign w_divEn = (r_state != IDLE);

  spi_sclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_gen (
    .clk    (clk),
    .clear  (clear),
    .i_en   (w_divEn),
    .o_tick (w_tick)
  );

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      r_state     <= IDLE;
      r_tx        <= '0;
      r_rx        <= '0;
      r_rxData    <= '0;
      r_bitCnt    <= '0;
      r_trailHold <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_sclk      <= SPI_CPOL;
      r_mosi      <= 1'b0;
      r_csN       <= 1'b1;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_tx        <= txData;
            r_csN       <= 1'b0;
            r_busy      <= 1'b1;
            r_mosi      <= first_bit(txData);
            r_bitCnt    <= '0;
            r_trailHold <= 1'b0;
            r_state     <= LEAD;
          end
        end
        LEAD: begin
          if (w_tick) begin
            r_sclk <= ~SPI_CPOL;
            if (CAP_ON_LEAD) r_rx <= capture(r_rx, miso);
            r_state <= HIGH;
          end
        end
        HIGH: begin
          if (w_tick) begin
            r_sclk   <= SPI_CPOL;
            r_bitCnt <= r_bitCnt + BW'(1);
            if (r_bitCnt == BW'(WIDTH - 1)) begin
              r_state <= TRAIL;
            end else begin
              r_tx    <= shift_tx(r_tx);
              r_mosi  <= first_bit(shift_tx(r_tx));
              r_state <= LOW;
            end
          end
        end
        LOW: begin
          if (w_tick) begin
            r_sclk <= ~SPI_CPOL;
            if (CAP_ON_LEAD) r_rx <= capture(r_rx, miso);
            r_state <= HIGH;
          end
        end
        TRAIL: begin
          // Two half-periods: the final SCLK-low phase, then the CS hold.
          if (w_tick) begin
            if (!r_trailHold) begin
              r_trailHold <= 1'b1;
            end else begin
              r_trailHold <= 1'b0;
              r_csN       <= 1'b1;
              r_busy      <= 1'b0;
              r_mosi      <= 1'b0;
              r_done      <= 1'b1;
              r_rxData    <= r_rx;
              r_bitCnt    <= '0;
              r_state     <= IDLE;
            end
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign rxData = r_rxData;
  assign sclk   = r_sclk;
  assign mosi   = r_mosi;
  assign csN    = r_csN;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: three configurations (8b/div2/MSB, 8b/div1/MSB, 8b/div2/LSB)
// with a loopback or slave-model MISO source and a received-word scoreboard.
module tb_spi_master_ctrl;

  logic clk = 1'b0;
  logic clear = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance 0: WIDTH=8, CLK_DIV=2, MSB first
  logic       d0_start = 1'b0;
  logic [7:0] d0_tx = '0;
  logic       d0_miso;
  logic       d0_busy, d0_done, d0_sclk, d0_mosi, d0_csN;
  logic [7:0] d0_rx;
  logic       d0_loop = 1'b1;
  logic [7:0] d0_slave_word = '0;
  logic [7:0] d0_slave_sr = '0;
  int         d0_rise = 0, d0_fall = 0, d0_ndone = 0, d0_lowcyc = 0, d0_viol = 0, d0_donecyc = 0;
  logic [7:0] d0_got[$];
  logic [7:0] d0_exp[$];
  bit         d0_bits[$];

  assign d0_miso = d0_loop ? d0_mosi : d0_slave_sr[7];

  spi_master_ctrl #(.WIDTH(8), .CLK_DIV(2), .MSB_FIRST(1)) u_dut0 (
    .clk(clk), .clear(clear), .start(d0_start), .txData(d0_tx), .miso(d0_miso),
    .busy(d0_busy), .done(d0_done), .rxData(d0_rx), .sclk(d0_sclk), .mosi(d0_mosi), .csN(d0_csN)
  );

  always @(negedge d0_csN) d0_slave_sr = d0_slave_word;
  always @(negedge d0_sclk) begin
    d0_fall++;
    if (!d0_csN) d0_slave_sr = {d0_slave_sr[6:0], 1'b0};
  end
  always @(posedge d0_sclk) begin
    d0_rise++;
    d0_bits.push_back(d0_mosi);
  end
  always @(negedge clk) begin
    if (d0_done) begin
      d0_ndone++;
      d0_donecyc = cyc;
      d0_got.push_back(d0_rx);
    end
    if (!d0_csN) d0_lowcyc++;
    if (d0_csN === 1'b1 && d0_sclk !== 1'b0) d0_viol++;
  end

  // Instance 1: WIDTH=8, CLK_DIV=1, MSB first, loopback
  logic       d1_start = 1'b0;
  logic [7:0] d1_tx = '0;
  logic       d1_busy, d1_done, d1_sclk, d1_mosi, d1_csN;
  logic [7:0] d1_rx;
  logic       d1_prevcs = 1'b1;
  logic [7:0] d1_got[$];
  logic [7:0] d1_exp[$];
  int         d1_donecyc[$];
  int         d1_falls[$];

  spi_master_ctrl #(.WIDTH(8), .CLK_DIV(1), .MSB_FIRST(1)) u_dut1 (
    .clk(clk), .clear(clear), .start(d1_start), .txData(d1_tx), .miso(d1_mosi),
    .busy(d1_busy), .done(d1_done), .rxData(d1_rx), .sclk(d1_sclk), .mosi(d1_mosi), .csN(d1_csN)
  );

  always @(negedge clk) begin
    if (d1_done) begin
      d1_got.push_back(d1_rx);
      d1_donecyc.push_back(cyc);
    end
    if (!d1_csN && d1_prevcs) d1_falls.push_back(cyc);
    d1_prevcs = d1_csN;
  end

  // Instance 2: WIDTH=8, CLK_DIV=2, LSB first, loopback
  logic       d2_start = 1'b0;
  logic [7:0] d2_tx = '0;
  logic       d2_busy, d2_done, d2_sclk, d2_mosi, d2_csN;
  logic [7:0] d2_rx;
  int         d2_ndone = 0, d2_donecyc = 0;
  logic [7:0] d2_got[$];
  logic [7:0] d2_exp[$];
  bit         d2_bits[$];

  spi_master_ctrl #(.WIDTH(8), .CLK_DIV(2), .MSB_FIRST(0)) u_dut2 (
    .clk(clk), .clear(clear), .start(d2_start), .txData(d2_tx), .miso(d2_mosi),
    .busy(d2_busy), .done(d2_done), .rxData(d2_rx), .sclk(d2_sclk), .mosi(d2_mosi), .csN(d2_csN)
  );

  always @(posedge d2_sclk) d2_bits.push_back(d2_mosi);
  always @(negedge clk) begin
    if (d2_done) begin
      d2_ndone++;
      d2_donecyc = cyc;
      d2_got.push_back(d2_rx);
    end
  end

  task automatic d0_clear_counters;
    d0_rise = 0; d0_fall = 0; d0_ndone = 0; d0_lowcyc = 0; d0_viol = 0;
    d0_bits.delete();
  endtask

  task automatic d0_kick(input logic [7:0] tx, output int t0);
    d0_tx = tx;
    d0_start = 1'b1;
    @(posedge clk); #1;
    t0 = cyc;
    d0_start = 1'b0;
  endtask

  task automatic d0_wait_done(input int n);
    for (int i = 0; i < 400 && d0_ndone < n; i++) @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    clear = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (d0_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", d0_busy); end
    checks++; if (d0_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", d0_done); end
    checks++; if (d0_rx !== 8'h00) begin errors++; $display("FAIL reset_rx got %h want 00", d0_rx); end
    checks++; if (d0_sclk !== 1'b0) begin errors++; $display("FAIL reset_sclk got %b want 0", d0_sclk); end
    checks++; if (d0_mosi !== 1'b0) begin errors++; $display("FAIL reset_mosi got %b want 0", d0_mosi); end
    checks++; if (d0_csN !== 1'b1) begin errors++; $display("FAIL reset_csN got %b want 1", d0_csN); end
    checks++; if (d1_csN !== 1'b1 || d1_busy !== 1'b0) begin errors++; $display("FAIL reset_d1 got csN=%b busy=%b want 1/0", d1_csN, d1_busy); end
    checks++; if (d2_csN !== 1'b1 || d2_busy !== 1'b0) begin errors++; $display("FAIL reset_d2 got csN=%b busy=%b want 1/0", d2_csN, d2_busy); end
    clear = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_loopback;
    int t0;
    logic [7:0] v;
    d0_loop = 1'b1;
    d0_clear_counters();
    d0_exp.push_back(8'hA5);
    d0_kick(8'hA5, t0);
    checks++; if (d0_csN !== 1'b0 || d0_busy !== 1'b1) begin errors++; $display("FAIL lb_start got csN=%b busy=%b want 0/1", d0_csN, d0_busy); end
    d0_wait_done(1);
    checks++; if (d0_ndone != 1) begin errors++; $display("FAIL lb_done_count got %0d want 1", d0_ndone); end
    checks++; if (d0_donecyc - t0 != 36) begin errors++; $display("FAIL lb_done_latency got %0d want 36", d0_donecyc - t0); end
    checks++; if (d0_lowcyc != 36) begin errors++; $display("FAIL lb_cs_low_cycles got %0d want 36", d0_lowcyc); end
    v = '0;
    foreach (d0_bits[i]) v = {v[6:0], d0_bits[i]};
    checks++; if (d0_bits.size() != 8 || v !== 8'hA5) begin errors++; $display("FAIL lb_mosi_order got %h (%0d bits) want a5 (8 bits)", v, d0_bits.size()); end
    checks++;
    if (d0_got.size() == 0 || d0_exp.size() == 0) begin
      errors++; $display("FAIL lb_rx got no word want a5");
    end else begin
      logic [7:0] g, e;
      g = d0_got.pop_front(); e = d0_exp.pop_front();
      if (g !== e) begin errors++; $display("FAIL lb_rx got %h want %h", g, e); end
    end
  endtask

  task automatic test_slave;
    int t0;
    logic [7:0] v;
    d0_loop = 1'b0;
    d0_slave_word = 8'h3C;
    d0_clear_counters();
    d0_exp.push_back(8'h3C);
    d0_kick(8'hFF, t0);
    d0_wait_done(1);
    checks++; if (d0_rise != 8) begin errors++; $display("FAIL slv_rise_count got %0d want 8", d0_rise); end
    checks++; if (d0_fall != 8) begin errors++; $display("FAIL slv_fall_count got %0d want 8", d0_fall); end
    checks++; if (d0_viol != 0) begin errors++; $display("FAIL slv_sclk_idle got %0d violations want 0", d0_viol); end
    v = '0;
    foreach (d0_bits[i]) v = {v[6:0], d0_bits[i]};
    checks++; if (v !== 8'hFF) begin errors++; $display("FAIL slv_mosi got %h want ff", v); end
    checks++;
    if (d0_got.size() == 0 || d0_exp.size() == 0) begin
      errors++; $display("FAIL slv_rx got no word want 3c");
    end else begin
      logic [7:0] g, e;
      g = d0_got.pop_front(); e = d0_exp.pop_front();
      if (g !== e) begin errors++; $display("FAIL slv_rx got %h want %h", g, e); end
    end
    d0_loop = 1'b1;
  endtask

  task automatic test_ignore_start;
    int t0;
    d0_clear_counters();
    d0_exp.push_back(8'h96);
    d0_kick(8'h96, t0);
    repeat (9) @(posedge clk);
    #1;
    d0_tx = 8'h00;
    d0_start = 1'b1;
    @(posedge clk); #1;
    d0_start = 1'b0;
    checks++; if (d0_busy !== 1'b1) begin errors++; $display("FAIL ign_busy got %b want 1", d0_busy); end
    d0_wait_done(1);
    repeat (40) @(posedge clk);
    #1;
    checks++; if (d0_ndone != 1) begin errors++; $display("FAIL ign_done_count got %0d want 1", d0_ndone); end
    checks++;
    if (d0_got.size() == 0 || d0_exp.size() == 0) begin
      errors++; $display("FAIL ign_rx got no word want 96");
    end else begin
      logic [7:0] g, e;
      g = d0_got.pop_front(); e = d0_exp.pop_front();
      if (g !== e) begin errors++; $display("FAIL ign_rx got %h want %h", g, e); end
    end
    checks++; if (d0_rx !== 8'h96) begin errors++; $display("FAIL ign_rx_hold got %h want 96", d0_rx); end
  endtask

  task automatic test_abort;
    int t0;
    d0_clear_counters();
    d0_kick(8'hC3, t0);
    repeat (15) @(posedge clk);
    #1;
    clear = 1'b0;
    #1;
    checks++; if (d0_csN !== 1'b1) begin errors++; $display("FAIL abort_csN got %b want 1", d0_csN); end
    checks++; if (d0_sclk !== 1'b0) begin errors++; $display("FAIL abort_sclk got %b want 0", d0_sclk); end
    checks++; if (d0_busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", d0_busy); end
    repeat (2) @(posedge clk);
    #1;
    clear = 1'b1;
    repeat (60) @(posedge clk);
    #1;
    checks++; if (d0_ndone != 0) begin errors++; $display("FAIL abort_no_done got %0d want 0", d0_ndone); end
    checks++; if (d0_rx !== 8'h00) begin errors++; $display("FAIL abort_rx got %h want 00", d0_rx); end
    d0_exp.push_back(8'h5A);
    d0_kick(8'h5A, t0);
    d0_wait_done(1);
    checks++; if (d0_ndone != 1) begin errors++; $display("FAIL abort_retry_done got %0d want 1", d0_ndone); end
    checks++;
    if (d0_got.size() == 0 || d0_exp.size() == 0) begin
      errors++; $display("FAIL abort_retry_rx got no word want 5a");
    end else begin
      logic [7:0] g, e;
      g = d0_got.pop_front(); e = d0_exp.pop_front();
      if (g !== e) begin errors++; $display("FAIL abort_retry_rx got %h want %h", g, e); end
    end
  endtask

  task automatic test_back_to_back;
    int t0;
    d1_got.delete(); d1_donecyc.delete(); d1_falls.delete();
    d1_exp.push_back(8'h81);
    d1_exp.push_back(8'h7E);
    d1_tx = 8'h81;
    d1_start = 1'b1;
    @(posedge clk); #1;
    t0 = cyc;
    d1_tx = 8'h7E;
    for (int i = 0; i < 200 && d1_got.size() < 2; i++) begin
      @(posedge clk); #1;
      if (d1_falls.size() >= 2) d1_start = 1'b0;
    end
    d1_start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (d1_got.size() != 2 || d1_donecyc.size() != 2 || d1_falls.size() != 2) begin
      errors++;
      $display("FAIL b2b_count got %0d words %0d cs falls want 2/2", d1_got.size(), d1_falls.size());
    end else begin
      checks++; if (d1_falls[0] != t0) begin errors++; $display("FAIL b2b_first_cs got %0d want %0d", d1_falls[0], t0); end
      checks++; if (d1_donecyc[0] - t0 != 18) begin errors++; $display("FAIL b2b_len1 got %0d want 18", d1_donecyc[0] - t0); end
      checks++; if (d1_falls[1] - d1_donecyc[0] != 1) begin errors++; $display("FAIL b2b_gap got %0d want 1", d1_falls[1] - d1_donecyc[0]); end
      checks++; if (d1_donecyc[1] - d1_falls[1] != 18) begin errors++; $display("FAIL b2b_len2 got %0d want 18", d1_donecyc[1] - d1_falls[1]); end
      for (int k = 0; k < 2; k++) begin
        logic [7:0] g, e;
        g = d1_got.pop_front(); e = d1_exp.pop_front();
        checks++; if (g !== e) begin errors++; $display("FAIL b2b_rx%0d got %h want %h", k, g, e); end
      end
    end
  endtask

  task automatic test_lsb_first;
    int t0;
    int ones;
    d2_bits.delete();
    d2_ndone = 0;
    d2_exp.push_back(8'h01);
    d2_tx = 8'h01;
    d2_start = 1'b1;
    @(posedge clk); #1;
    t0 = cyc;
    d2_start = 1'b0;
    for (int i = 0; i < 400 && d2_ndone < 1; i++) @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
    checks++; if (d2_ndone != 1) begin errors++; $display("FAIL lsb_done_count got %0d want 1", d2_ndone); end
    checks++; if (d2_donecyc - t0 != 36) begin errors++; $display("FAIL lsb_latency got %0d want 36", d2_donecyc - t0); end
    ones = 0;
    for (int i = 1; i < d2_bits.size(); i++) ones += int'(d2_bits[i]);
    checks++;
    if (d2_bits.size() != 8 || d2_bits[0] != 1'b1 || ones != 0) begin
      errors++;
      $display("FAIL lsb_mosi got %0d bits first=%0d later_ones=%0d want 8/1/0", d2_bits.size(),
               (d2_bits.size() > 0) ? int'(d2_bits[0]) : -1, ones);
    end
    checks++;
    if (d2_got.size() == 0 || d2_exp.size() == 0) begin
      errors++; $display("FAIL lsb_rx got no word want 01");
    end else begin
      logic [7:0] g, e;
      g = d2_got.pop_front(); e = d2_exp.pop_front();
      if (g !== e) begin errors++; $display("FAIL lsb_rx got %h want %h", g, e); end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_loopback();
    test_slave();
    test_ignore_start();
    test_abort();
    test_back_to_back();
    test_lsb_first();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
